alu_cmd_sequencer: RTL and testbench

Command-side driver for the 8-bit register-file/ALU CPU block. It accepts host commands over a valid/ready handshake and buffers them in a small FIFO. It replays them onto the CPU's `ce`/`load`/`opcode`/`data_in` strobe interface with the CPU's two-cycle execute timing honoured, then captures `data_out` after each execute and returns it as a one-cycle result pulse. It sits between the host/test controller and the CPU.

---
 rtl/alu_seq_pkg.sv | 53 +++++
 rtl/alu_seq_fifo.sv | 58 +++++
 rtl/alu_cmd_sequencer.sv | 118 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the ALU command sequencer: FSM state
// encoding, the 18-bit command layout and its pack/unpack functions.
package alu_seq_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  // Command word layout: {load, reg[2:0], op[3:0], data[7:0], cin, cout}
  localparam int CMD_W    = 18;
  localparam int COUT_OFF = 0;
  localparam int CIN_OFF  = 1;
  localparam int DATA_OFF = 2;
  localparam int OP_OFF   = 10;
  localparam int REG_OFF  = 14;
  localparam int LOAD_OFF = 17;

  typedef struct packed {
    logic       load;
    logic [2:0] rsel;
    logic [3:0] op;
    logic [7:0] data;
    logic       cin;
    logic       cout;
  } cmd_t;

  function automatic logic [CMD_W-1:0] pack_cmd(input logic       load,
                                                 input logic [2:0] rsel,
                                                 input logic [3:0] op,
                                                 input logic [7:0] data,
                                                 input logic       cin,
                                                 input logic       cout);
    logic [CMD_W-1:0] v;
    v                  = '0;
    v[LOAD_OFF]        = load;
    v[REG_OFF +: 3]    = rsel;
    v[OP_OFF +: 4]     = op;
    v[DATA_OFF +: 8]   = data;
    v[CIN_OFF]         = cin;
    v[COUT_OFF]        = cout;
    return v;
  endfunction

  function automatic cmd_t unpack_cmd(input logic [CMD_W-1:0] v);
    cmd_t c;
    c.load = v[LOAD_OFF];
    c.rsel = v[REG_OFF +: 3];
    c.op   = v[OP_OFF +: 4];
    c.data = v[DATA_OFF +: 8];
    c.cin  = v[CIN_OFF];
    c.cout = v[COUT_OFF];
    return c;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO for queued host commands. DEPTH must be a power of two
// so the pointers wrap naturally; the occupancy count is registered and
// the full/empty flags are decoded from it.
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Replays buffered host commands onto the CPU strobe interface, honouring
// its two-cycle execute, and returns each execute result as a pulse.
// Optional feature: define ALU_SEQ_OPCNT_EN for the 16-bit completed-execute
// counter on op_count; otherwise op_count is tied to zero.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_load,
  input  logic [2:0]  cmd_reg,
  input  logic [3:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_cin,
  input  logic        cmd_cout,
  output logic        cpu_ce,
  output logic        cpu_load,
  output logic [6:0]  cpu_opcode,
  output logic [7:0]  cpu_data_in,
  output logic        cpu_cin,
  output logic        cpu_cout,
  input  logic [7:0]  cpu_data_out,
  output logic        res_valid,
  output logic [7:0]  res_data,
  output logic        busy,
  output logic [15:0] op_count
);

  state_t           state;
  logic [CMD_W-1:0] fifo_wdata;
  logic [CMD_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  cmd_t             head;

  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign fifo_wdata = pack_cmd(cmd_load, cmd_reg, cmd_op, cmd_data, cmd_cin, cmd_cout);
  assign head       = unpack_cmd(fifo_rdata);
  // A new command is issued from IDLE, or straight after a load still on
  // the bus; executes must drain through WAIT/CAPTURE first.
  assign pop        = !fifo_empty && ((state == IDLE) || ((state == ISSUE) && cpu_load));
  assign busy       = (state != IDLE) || !fifo_empty;

  alu_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencer FSM with registered CPU strobes and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cpu_ce      <= 1'b0;
      cpu_load    <= 1'b0;
      cpu_opcode  <= '0;
      cpu_data_in <= '0;
      cpu_cin     <= 1'b0;
      cpu_cout    <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
    end else begin
      cpu_ce    <= pop;
      res_valid <= 1'b0;
      if (pop) begin
        cpu_load    <= head.load;
        cpu_opcode  <= {head.rsel, (head.load ? 4'h0 : head.op)};
        cpu_data_in <= head.data;
        cpu_cin     <= head.cin;
        cpu_cout    <= head.cout;
      end
      case (state)
        IDLE:    if (pop) state <= ISSUE;
        ISSUE: begin
          if (!cpu_load)  state <= WAIT;
          else if (!pop)  state <= IDLE;
        end
        WAIT:    state <= CAPTURE;
        CAPTURE: begin
          res_data  <= cpu_data_out;
          res_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_OPCNT_EN
  logic [15:0] cnt_q;

  // Completed-execute counter, wraps at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt_q <= '0;
    else if (state == CAPTURE)  cnt_q <= cnt_q + 16'd1;
  end

  assign op_count = cnt_q;
`else
  assign op_count = 16'h0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a stub CPU (register file with a two-cycle
// execute, r0 <= r[sel] + {op,4'h0} + 8'h80) and two scoreboards, one for
// CPU strobes and one for execute results.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_load = 1'b0;
  logic [2:0]  cmd_reg = '0;
  logic [3:0]  cmd_op = '0;
  logic [7:0]  cmd_data = '0;
  logic        cmd_cin = 1'b0;
  logic        cmd_cout = 1'b0;
  logic        cpu_ce;
  logic        cpu_load;
  logic [6:0]  cpu_opcode;
  logic [7:0]  cpu_data_in;
  logic        cpu_cin;
  logic        cpu_cout;
  logic [7:0]  cpu_data_out;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        busy;
  logic [15:0] op_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [17:0] exp_strb[$];
  logic [7:0]  exp_res[$];
  int          res_cycs[$];
  logic [7:0]  mdl[8];
  int          acc_cyc, last_res_cyc, last_load_cyc;
  int          ce_run, max_run, guard, n_res, n_res_before;
  logic        stalled;
  logic [15:0] n_done;
  logic [17:0] ms;
  logic [7:0]  mr;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_load     (cmd_load),
    .cmd_reg      (cmd_reg),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_cin      (cmd_cin),
    .cmd_cout     (cmd_cout),
    .cpu_ce       (cpu_ce),
    .cpu_load     (cpu_load),
    .cpu_opcode   (cpu_opcode),
    .cpu_data_in  (cpu_data_in),
    .cpu_cin      (cpu_cin),
    .cpu_cout     (cpu_cout),
    .cpu_data_out (cpu_data_out),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .busy         (busy),
    .op_count     (op_count)
  );

  // Stub CPU: latch on ce, execute writes r0 one cycle later.
  logic [7:0] cr[8];
  logic       cpend;
  logic [2:0] csel;
  logic [3:0] cop;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) cr[i] <= 8'h0;
      cpend <= 1'b0;
      csel  <= '0;
      cop   <= '0;
    end else begin
      cpend <= cpu_ce && !cpu_load;
      if (cpu_ce && cpu_load) cr[cpu_opcode[6:4]] <= cpu_data_in;
      if (cpu_ce && !cpu_load) begin
        csel <= cpu_opcode[6:4];
        cop  <= cpu_opcode[3:0];
      end
      if (cpend) cr[0] <= cr[csel] + {cop, 4'h0} + 8'h80;
    end
  end
  assign cpu_data_out = cr[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic send(input logic ld, input logic [2:0] sel, input logic [3:0] op,
                      input logic [7:0] dat);
    logic ci, co;
    logic [7:0] r;
    int n;
    ci = 1'($urandom_range(0, 1));
    co = 1'($urandom_range(0, 1));
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_reg   = sel;
    cmd_op    = op;
    cmd_data  = dat;
    cmd_cin   = ci;
    cmd_cout  = co;
    n = 0;
    while (!cmd_ready && n < 100) begin
      stalled = 1'b1;
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 1);
      cmd_valid = 1'b0;
    end else begin
      acc_cyc = cyc + 1;
      exp_strb.push_back({ld, sel, (ld ? 4'h0 : op), dat, ci, co});
      if (ld) mdl[sel] = dat;
      else begin
        r = mdl[sel] + {op, 4'h0} + 8'h80;
        mdl[0] = r;
        exp_res.push_back(r);
      end
    end
  endtask

  task automatic stop();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_res.size() != 0 || exp_strb.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 300), 1);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: strobe and result scoreboards, execute quiet window.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (guard > 0) begin
          chk("ce_quiet", 32'(cpu_ce), 0);
          guard--;
        end
        if (cpu_ce) begin
          ce_run++;
          if (ce_run > max_run) max_run = ce_run;
          if (exp_strb.size() == 0) chk("strb_unexp", 32'(cpu_ce), 0);
          else begin
            ms = exp_strb.pop_front();
            chk("strb_load", 32'(cpu_load), 32'(ms[17]));
            chk("strb_opcode", 32'(cpu_opcode), 32'(ms[16:10]));
            if (ms[17]) chk("strb_data", 32'(cpu_data_in), 32'(ms[9:2]));
            chk("strb_cin", 32'(cpu_cin), 32'(ms[1]));
            chk("strb_cout", 32'(cpu_cout), 32'(ms[0]));
          end
          if (cpu_load) last_load_cyc = cyc;
          else guard = 2;
        end else ce_run = 0;
        if (res_valid) begin
          n_res++;
          n_done = n_done + 16'd1;
          res_cycs.push_back(cyc);
          last_res_cyc = cyc;
          if (exp_res.size() == 0) chk("res_unexp", 32'(res_valid), 0);
          else begin
            mr = exp_res.pop_front();
            chk("res_data", 32'(res_data), 32'(mr));
          end
`ifdef ALU_SEQ_OPCNT_EN
          chk("op_count_track", 32'(op_count), 32'(n_done));
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) mdl[i] = 8'h0;
    ce_run = 0; max_run = 0; guard = 0; n_res = 0; n_done = 16'h0;
    stalled = 1'b0; acc_cyc = 0; last_res_cyc = 0; last_load_cyc = 0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_cpu_ce", 32'(cpu_ce), 0);
    chk("rst_cpu_load", 32'(cpu_load), 0);
    chk("rst_cpu_opcode", 32'(cpu_opcode), 0);
    chk("rst_cpu_data_in", 32'(cpu_data_in), 0);
    chk("rst_cpu_cin_cout", 32'({cpu_cin, cpu_cout}), 0);
    chk("rst_res", 32'({res_valid, res_data}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_count", 32'(op_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // Load R1 then a single execute from idle
    send(1'b1, 3'd1, 4'h0, 8'h05); stop(); wait_idle();
    chk("load_opcode", 32'(cpu_opcode), 32'h10);
    send(1'b0, 3'd1, 4'h2, 8'h00); stop(); wait_idle();
    chk("exec_latency", last_res_cyc - acc_cyc, 4);
    chk("exec_opcode", 32'(cpu_opcode), 32'h12);
    chk("exec_res_a5", 32'(res_data), 32'hA5);

    // Four back-to-back loads, then an execute that uses them
    max_run = 0;
    send(1'b1, 3'd0, 4'h9, 8'h11);
    send(1'b1, 3'd1, 4'h9, 8'h22);
    send(1'b1, 3'd2, 4'h9, 8'h33);
    send(1'b1, 3'd3, 4'h9, 8'h44);
    stop(); wait_idle();
    chk("load_run", 32'(max_run), 4);
    send(1'b0, 3'd3, 4'h1, 8'h00); stop(); wait_idle();

    // Six executes pushed continuously into a DEPTH=4 FIFO
    res_cycs.delete();
    stalled = 1'b0;
    for (int i = 0; i < 6; i++)
      send(1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 8'h00);
    stop(); wait_idle();
    chk("burst_count", 32'(res_cycs.size()), 6);
    chk("burst_stall", 32'(stalled), 1);
    for (int i = 1; i < res_cycs.size(); i++)
      chk("burst_gap", res_cycs[i] - res_cycs[i-1], 4);

    // Execute, load, execute interleaved
    res_cycs.delete();
    send(1'b0, 3'd2, 4'h5, 8'h00);
    send(1'b1, 3'd5, 4'h0, 8'h5C);
    send(1'b0, 3'd5, 4'h3, 8'h00);
    stop(); wait_idle();
    chk("ilv_count", 32'(res_cycs.size()), 2);
    if (res_cycs.size() > 0) chk("ilv_load_slot", last_load_cyc - res_cycs[0], 1);

    // Reset while an execute is in WAIT
    send(1'b0, 3'd2, 4'h7, 8'h00); stop();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    exp_res.delete();
    exp_strb.delete();
    for (int i = 0; i < 8; i++) mdl[i] = 8'h0;
    n_done = 16'h0;
    guard = 0;
    n_res_before = n_res;
    chk("mid_rst_cpu", 32'({cpu_ce, cpu_load, cpu_opcode, cpu_data_in, cpu_cin, cpu_cout}), 0);
    chk("mid_rst_res", 32'({res_valid, res_data}), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_op_count", 32'(op_count), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_rst_no_res", n_res - n_res_before, 0);
    chk("post_rst_busy", 32'(busy), 0);
    send(1'b1, 3'd1, 4'h0, 8'h0F);
    send(1'b0, 3'd1, 4'h4, 8'h00);
    stop(); wait_idle();

`ifdef ALU_SEQ_OPCNT_EN
    chk("op_count_val", 32'(op_count), 32'(n_done));
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    n_done = 16'hFFFF;
    send(1'b0, 3'd0, 4'h1, 8'h00); stop(); wait_idle();
    chk("op_count_wrap", 32'(op_count), 0);
`else
    chk("op_count_tied", 32'(op_count), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
